// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, end marker and
// the 20-bit instruction field map that the decoder also relies on.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      B0,
      B1,
      B2,
      WR,
      DONE,
      ERR
   } ld_state_t;

   localparam logic [7:0] END_MARKER = 8'hFF;
   localparam int INSTR_BITS = 20;
   localparam int OPCODE_MSB = 19;
   localparam int OPCODE_LSB = 15;

   // Big-endian packing: the low nibble of the first byte carries instr[19:16].
   function automatic logic [INSTR_BITS-1:0] pack_word(input logic [3:0] hi,
                                                       input logic [7:0] mid,
                                                       input logic [7:0] lo);
      return {hi, mid, lo};
   endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Packs a UART byte stream into 20-bit instruction words and writes them to
// instruction memory from address 0, stalling the core until the load ends.
module instr_mem_loader
   import loader_pkg::*;
#(
   parameter int BITS    = INSTR_BITS,
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [BITS-1:0]   imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

   ld_state_t         state;
   ld_state_t         next_state;
   logic [3:0]        hi_q;
   logic [7:0]        mid_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BITS-1:0]   wdata_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              hs;
   logic              tmo_hit;
   logic              overflow;

   assign hs       = rx_valid & rx_ready;
   assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));
   assign overflow = (count_q == DEPTH_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Handshake only happens in B0..B2, so a valid byte there always advances.
   always_comb begin
      next_state = state;
      rx_ready   = 1'b0;
      imem_we    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         IDLE: begin
            if (start) next_state = B0;
         end
         B0: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid) begin
               if (rx_data == END_MARKER)              next_state = DONE;
               else if (rx_data[7:4] != 4'h0 || overflow) next_state = ERR;
               else                                    next_state = B1;
            end
         end
         B1: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid)     next_state = B2;
            else if (tmo_hit) next_state = ERR;
         end
         B2: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid)     next_state = WR;
            else if (tmo_hit) next_state = ERR;
         end
         WR: begin
            imem_we    = 1'b1;
            busy       = 1'b1;
            next_state = B0;
         end
         DONE: begin
            done = 1'b1;
            if (start) next_state = B0;
         end
         ERR: begin
            error = 1'b1;
            if (start) next_state = B0;
         end
         default: next_state = IDLE;
      endcase
   end

   assign cpu_hold = busy;

   // Address and data are captured on the last byte so they stay stable after WR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q    <= '0;
         mid_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (state == B0 && hs) hi_q <= rx_data[3:0];
         if (state == B1 && hs) mid_q <= rx_data;
         if (state == B2 && hs) begin
            wdata_q <= BITS'(pack_word(hi_q, mid_q, rx_data));
            addr_q  <= count_q[ADDR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if ((state == IDLE || state == DONE || state == ERR) && start) begin
         count_q <= '0;
      end else if (state == WR) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Inter-byte timer only runs mid-word; the host may pause freely between words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else if ((state == B1 || state == B2) && !hs) begin
         tmo_q <= tmo_q + 1'b1;
      end else begin
         tmo_q <= '0;
      end
   end

   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign word_count = count_q;

endmodule
